// File: rtl/mult_div_seq_if.sv
// Handshake/bus bundle for mult_div_seq.
//   master: control FSM side (drives start/op/a/b, observes status and result)
//   slave : sequencer side
//   start      request pulse, sampled only while the sequencer is not busy
//   op[1:0]    00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b       multiplicand/dividend, multiplier/divisor
//   busy       high while iterating
//   done       one-cycle completion strobe
//   div0       one-cycle divide-by-zero strobe, coincident with done
//   hi, lo     product halves, or remainder/quotient
interface mult_div_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div0;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, div0, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, div0, hi, lo
    );
endinterface

// File: rtl/mult_div_seq.sv
// Iterative signed/unsigned multiply/divide sequencer, one bit per cycle.
// Multiply is shift-add on a 2*WIDTH accumulator; divide is restoring
// shift-subtract. Operands are converted to magnitudes at start and the
// result sign is applied on the final iteration.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high; clears all state and outputs
//   bus    mult_div_seq_if.slave (start/op/a/b in; busy/done/div0/hi/lo out)
// WIDTH must be >= 4 and even.
module mult_div_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset,
    mult_div_seq_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned ACC_W = 2 * WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    logic [1:0]       state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             is_div_q,  is_div_d;
    logic             neg_res_q, neg_res_d;   // negate product / quotient
    logic             neg_rem_q, neg_rem_d;   // negate remainder
    logic [WIDTH-1:0] opnd_q,    opnd_d;      // |multiplicand| or |divisor|
    logic [ACC_W-1:0] acc_q,     acc_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic             div0_q,    div0_d;
    logic [WIDTH-1:0] hi_q,      hi_d;
    logic [WIDTH-1:0] lo_q,      lo_d;

    logic             signed_op;
    logic             sgn_a, sgn_b;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [ACC_W-1:0] acc_step;
    logic [ACC_W-1:0] prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    // Operand magnitudes, single-iteration datapath and final sign fixup
    always_comb begin
        signed_op = ~bus.op[0];
        sgn_a     = signed_op & bus.a[WIDTH-1];
        sgn_b     = signed_op & bus.b[WIDTH-1];
        mag_a     = sgn_a ? WIDTH'(-bus.a) : bus.a;
        mag_b     = sgn_b ? WIDTH'(-bus.b) : bus.b;

        // Multiply: upper half accumulates, lower half shifts out the multiplier
        mul_sum   = {1'b0, acc_q[ACC_W-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : (WIDTH+1)'(0));

        // Divide: partial remainder in upper half, dividend/quotient in lower half
        div_sh    = acc_q[ACC_W-1:WIDTH-1];
        div_diff  = div_sh - {1'b0, opnd_q};
        div_ge    = (div_sh >= {1'b0, opnd_q});

        if (is_div_q) begin
            acc_step = div_ge ? {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                              : {div_sh[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b0};
        end else begin
            acc_step = {mul_sum, acc_q[WIDTH-1:1]};
        end

        prod_fix = neg_res_q ? ACC_W'(-acc_step) : acc_step;
        quo_fix  = neg_res_q ? WIDTH'(-acc_step[WIDTH-1:0]) : acc_step[WIDTH-1:0];
        rem_fix  = neg_rem_q ? WIDTH'(-acc_step[ACC_W-1:WIDTH]) : acc_step[ACC_W-1:WIDTH];
    end

    // Next-state and output logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        div0_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            S_IDLE, S_FIN: begin
                if (bus.start) begin
                    if (bus.op[1] && (bus.b == '0)) begin
                        // Zero divisor: report immediately, result registers untouched
                        state_d = S_FIN;
                        done_d  = 1'b1;
                        div0_d  = 1'b1;
                    end else begin
                        state_d   = S_RUN;
                        busy_d    = 1'b1;
                        cnt_d     = CNT_W'(WIDTH);
                        is_div_d  = bus.op[1];
                        neg_res_d = sgn_a ^ sgn_b;
                        neg_rem_d = bus.op[1] & sgn_a;
                        opnd_d    = bus.op[1] ? mag_b : mag_a;
                        acc_d     = {WIDTH'(0), (bus.op[1] ? mag_a : mag_b)};
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                acc_d = acc_step;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_FIN;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[ACC_W-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            opnd_q    <= '0;
            acc_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            div0_q    <= div0_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.div0 = div0_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mult_div_seq.sv
// Testbench for mult_div_seq: a 32-bit and an 8-bit instance share clk/reset.
// A transaction-level model predicts busy/done/div0/hi/lo each cycle from
// plain integer arithmetic; directed vectors also carry literal expectations.
module tb_mult_div_seq;
    logic clk;
    logic reset;

    mult_div_seq_if #(.WIDTH(32)) bus32 ();
    mult_div_seq_if #(.WIDTH(8))  bus8 ();

    mult_div_seq #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
    mult_div_seq #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8));

    // Bench-side stimulus, index 0 = 32-bit DUT, 1 = 8-bit DUT
    logic        st  [2];
    logic [1:0]  opv [2];
    logic [31:0] av  [2];
    logic [31:0] bv  [2];

    logic        o_busy [2];
    logic        o_done [2];
    logic        o_div0 [2];
    logic [31:0] o_hi   [2];
    logic [31:0] o_lo   [2];

    assign bus32.start = st[0];
    assign bus32.op    = opv[0];
    assign bus32.a     = av[0];
    assign bus32.b     = bv[0];
    assign bus8.start  = st[1];
    assign bus8.op     = opv[1];
    assign bus8.a      = av[1][7:0];
    assign bus8.b      = bv[1][7:0];

    assign o_busy[0] = bus32.busy;
    assign o_done[0] = bus32.done;
    assign o_div0[0] = bus32.div0;
    assign o_hi[0]   = bus32.hi;
    assign o_lo[0]   = bus32.lo;
    assign o_busy[1] = bus8.busy;
    assign o_done[1] = bus8.done;
    assign o_div0[1] = bus8.div0;
    assign o_hi[1]   = {24'h0, bus8.hi};
    assign o_lo[1]   = {24'h0, bus8.lo};

    int asserts = 0;
    int fails   = 0;
    logic chk_en = 1'b0;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int width_of(input int i);
        return (i == 0) ? 32 : 8;
    endfunction

    function automatic logic [31:0] wmask(input int i);
        return (i == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    endfunction

    // Reference result {hi, lo} using plain integer arithmetic on w-bit operands
    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input int w);
        longint mask, sa, sb, p, q, r;
        logic [31:0] rh, rl;
        mask = (longint'(1) << w) - 1;
        sa = longint'(a) & mask;
        sb = longint'(b) & mask;
        if (!op[0] && a[w-1]) sa = sa - (longint'(1) << w);
        if (!op[0] && b[w-1]) sb = sb - (longint'(1) << w);
        if (!op[1]) begin
            p  = sa * sb;
            rh = 32'((p >> w) & mask);
            rl = 32'(p & mask);
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            rh = 32'(r & mask);
            rl = 32'(q & mask);
        end
        return {rh, rl};
    endfunction

    // Transaction-level model: expected outputs after each edge
    logic        exp_busy [2];
    logic        exp_done [2];
    logic        exp_div0 [2];
    logic [31:0] exp_hi   [2];
    logic [31:0] exp_lo   [2];
    logic [63:0] pend     [2];
    int          rem      [2];

    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                exp_busy[i] <= 1'b0;
                exp_done[i] <= 1'b0;
                exp_div0[i] <= 1'b0;
                exp_hi[i]   <= '0;
                exp_lo[i]   <= '0;
                rem[i]      <= 0;
            end else if (rem[i] > 0) begin
                rem[i] <= rem[i] - 1;
                if (rem[i] == 1) begin
                    exp_busy[i] <= 1'b0;
                    exp_done[i] <= 1'b1;
                    exp_hi[i]   <= pend[i][63:32];
                    exp_lo[i]   <= pend[i][31:0];
                end
            end else begin
                exp_done[i] <= 1'b0;
                exp_div0[i] <= 1'b0;
                if (st[i]) begin
                    if (opv[i][1] && ((bv[i] & wmask(i)) == 32'h0)) begin
                        exp_done[i] <= 1'b1;
                        exp_div0[i] <= 1'b1;
                    end else begin
                        exp_busy[i] <= 1'b1;
                        rem[i]      <= width_of(i);
                        pend[i]     <= ref_result(opv[i], av[i], bv[i], width_of(i));
                    end
                end
            end
        end
    end

    // Per-cycle comparison of both DUTs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                asserts++;
                if (o_busy[i] !== exp_busy[i] || o_done[i] !== exp_done[i] ||
                    o_div0[i] !== exp_div0[i] || o_hi[i] !== exp_hi[i] || o_lo[i] !== exp_lo[i]) begin
                    fails++;
                    $display("FAIL cycle_model dut%0d t=%0t got busy=%b done=%b div0=%b hi=%h lo=%h expected busy=%b done=%b div0=%b hi=%h lo=%h",
                             i, $time, o_busy[i], o_done[i], o_div0[i], o_hi[i], o_lo[i],
                             exp_busy[i], exp_done[i], exp_div0[i], exp_hi[i], exp_lo[i]);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the start edge
    task automatic issue(input int i, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        opv[i] = op;
        av[i]  = a;
        bv[i]  = b;
        st[i]  = 1'b1;
        @(negedge clk);
        st[i]  = 1'b0;
        av[i]  = $urandom;
        bv[i]  = $urandom;
    endtask

    // lat counts from 1 at the negedge after the start edge
    task automatic wait_done(input int i, input int budget, output int lat, output int busy_cnt);
        lat = 1;
        busy_cnt = 0;
        while (!o_done[i] && lat <= budget) begin
            if (o_busy[i]) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        if (lat > budget) begin
            asserts++;
            fails++;
            $display("FAIL done_timeout dut%0d: no done within %0d cycles", i, budget);
        end
    endtask

    task automatic do_op(input int i, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input string nm);
        int lat, bc;
        issue(i, op, a, b);
        wait_done(i, 60, lat, bc);
        chk({nm, "_latency"}, 32'(lat), 32'(width_of(i) + 1));
        chk({nm, "_busy_cycles"}, 32'(bc), 32'(width_of(i)));
        chk({nm, "_hi"}, o_hi[i], eh);
        chk({nm, "_lo"}, o_lo[i], el);
        chk({nm, "_div0"}, 32'(o_div0[i]), 32'h0);
        @(negedge clk);
        chk({nm, "_done_drop"}, 32'(o_done[i]), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bc, ndone;
        logic [63:0] r;
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        int          ri;

        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            st[i] = 1'b0; opv[i] = 2'b00; av[i] = '0; bv[i] = '0;
        end
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        chk_en = 1'b1;

        chk("reset_busy", 32'(o_busy[0]), 32'h0);
        chk("reset_done", 32'(o_done[0]), 32'h0);
        chk("reset_hi",   o_hi[0], 32'h0);
        chk("reset_lo",   o_lo[0], 32'h0);

        do_op(0, OP_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_m3x7");
        do_op(0, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
        do_op(0, OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7d2");
        do_op(0, OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000, "div_minneg");

        // Divide by zero keeps the previous result
        do_op(0, OP_DIVU, 32'd68, 32'd7, 32'd5, 32'd9, "divu_preload");
        issue(0, OP_DIV, 32'd1234, 32'd0);
        chk("div0_done", 32'(o_done[0]), 32'h1);
        chk("div0_flag", 32'(o_div0[0]), 32'h1);
        chk("div0_busy", 32'(o_busy[0]), 32'h0);
        chk("div0_hi",   o_hi[0], 32'd5);
        chk("div0_lo",   o_lo[0], 32'd9);
        @(negedge clk);
        chk("div0_done_drop", 32'(o_done[0]), 32'h0);
        chk("div0_flag_drop", 32'(o_div0[0]), 32'h0);

        // Start pulse mid-RUN (with a zero divisor) must be ignored
        issue(0, OP_MULT, 32'd100, 32'hFFFF_FFFB);
        repeat (4) @(negedge clk);
        opv[0] = OP_DIVU; av[0] = 32'd5; bv[0] = 32'd0; st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        wait_done(0, 60, lat, bc);
        chk("midrun_latency", 32'(lat), 32'd28);
        chk("midrun_hi",   o_hi[0], 32'hFFFF_FFFF);
        chk("midrun_lo",   o_lo[0], 32'hFFFF_FE0C);
        chk("midrun_div0", 32'(o_div0[0]), 32'h0);

        // Back-to-back: start held in the done cycle
        @(negedge clk);
        issue(0, OP_MULTU, 32'd6, 32'd7);
        wait_done(0, 60, lat, bc);
        chk("b2b_first_lo", o_lo[0], 32'd42);
        issue(0, OP_DIVU, 32'd100, 32'd7);
        chk("b2b_done_drop", 32'(o_done[0]), 32'h0);
        chk("b2b_busy",      32'(o_busy[0]), 32'h1);
        wait_done(0, 60, lat, bc);
        chk("b2b_latency", 32'(lat), 32'd33);
        chk("b2b_hi", o_hi[0], 32'd2);
        chk("b2b_lo", o_lo[0], 32'd14);
        @(negedge clk);

        // Reset between edges during RUN aborts immediately
        issue(0, OP_MULT, 32'd12345, 32'd678);
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_busy", 32'(o_busy[0]), 32'h0);
        chk("rst_done", 32'(o_done[0]), 32'h0);
        chk("rst_div0", 32'(o_div0[0]), 32'h0);
        chk("rst_hi",   o_hi[0], 32'h0);
        chk("rst_lo",   o_lo[0], 32'h0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (o_done[0]) ndone++;
        end
        chk("rst_no_done", 32'(ndone), 32'h0);

        // 8-bit instance
        do_op(1, OP_MULT, 32'hFFFF_FF80, 32'hFFFF_FF80, 32'h40, 32'h00, "w8_mult_min");
        do_op(1, OP_DIV,  32'h80,        32'hFF,        32'h00, 32'h80, "w8_div_minneg");
        do_op(1, OP_DIV,  32'hF9,        32'h02,        32'hFF, 32'hFD, "w8_div_m7d2");

        // Random operands on both widths, expectations from the reference model
        for (int k = 0; k < 10; k++) begin
            ri  = k % 2;
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (k % 3 == 0) ? 32'($urandom_range(1, 9)) : $urandom;
            if (rop[1] && ((rb & wmask(ri)) == 32'h0)) rb = 32'd1;
            r = ref_result(rop, ra, rb, width_of(ri));
            do_op(ri, rop, ra, rb, r[63:32], r[31:0], "rand");
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule
